// File: rtl/inst_fetch_responder.sv
// inst_fetch_responder: fetches a 32-bit instruction word as four little-endian byte reads
// over the 8-bit RAM port and returns it with a one-cycle HANDLED status.
module inst_fetch_responder #(
   parameter int ADDR_W = 32,
   parameter int STAT_W = 2,
   parameter logic [STAT_W-1:0] STAT_IDLE = 2'd0,
   parameter logic [STAT_W-1:0] STAT_BUSY = 2'd1,
   parameter logic [STAT_W-1:0] STAT_HANDLED = 2'd2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_access_enable,
   input  logic [ADDR_W-1:0] inst_access_addr,
   output logic [STAT_W-1:0] inst_access_stat,
   output logic [ADDR_W-1:0] inst_handled_addr,
   output logic [31:0]       inst_access_data,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic [7:0]        mem_din
);
   typedef enum logic [1:0] {IDLE, RD, DONE} state_t;
   state_t state;
   logic [ADDR_W-1:0] base;
   logic [2:0] cnt;
   logic [7:0] b0, b1, b2;
   // cnt=4 re-presents the last address; its byte arrives one cycle after it was first issued
   assign mem_a = (state == RD) ? base + ADDR_W'(cnt == 3'd4 ? 3'd3 : cnt) : '0;
   assign mem_wr = 1'b0;
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         cnt <= '0;
         base <= '0;
         b0 <= '0;
         b1 <= '0;
         b2 <= '0;
         inst_access_stat <= STAT_IDLE;
         inst_handled_addr <= '0;
         inst_access_data <= '0;
      end else begin
         case (state)
            IDLE: if (inst_access_enable) begin
               base <= inst_access_addr;
               cnt <= '0;
               state <= RD;
               inst_access_stat <= STAT_BUSY;
            end
            RD: if (!inst_access_enable) begin
               state <= IDLE;
               inst_access_stat <= STAT_IDLE;
            end else if (inst_access_addr != base) begin
               base <= inst_access_addr;
               cnt <= '0;
            end else if (cnt == 3'd4) begin
               inst_access_data <= {mem_din, b2, b1, b0};
               inst_handled_addr <= base;
               state <= DONE;
               inst_access_stat <= STAT_HANDLED;
            end else begin
               if (cnt == 3'd1) b0 <= mem_din;
               if (cnt == 3'd2) b1 <= mem_din;
               if (cnt == 3'd3) b2 <= mem_din;
               cnt <= cnt + 3'd1;
            end
            default: begin
               state <= IDLE;
               inst_access_stat <= STAT_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_inst_fetch_responder.sv
// tb_inst_fetch_responder: directed table-driven fetches plus redirect, enable-drop,
// reset and wrap sequences against a byte-wide RAM model with one-cycle read latency.
module tb_inst_fetch_responder;
   logic clk = 0, rst = 0, en = 0;
   logic [31:0] addr = 0;
   logic [1:0] stat;
   logic [31:0] haddr, data, mem_a;
   logic mem_wr;
   logic [7:0] mem_din = 0;
   int tests = 0, fails = 0, cyc = 0, last_h = 0;

   inst_fetch_responder dut (
      .clk(clk), .rst(rst), .inst_access_enable(en), .inst_access_addr(addr),
      .inst_access_stat(stat), .inst_handled_addr(haddr), .inst_access_data(data),
      .mem_a(mem_a), .mem_wr(mem_wr), .mem_din(mem_din)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM: fixed program bytes at 0x100..0x103, elsewhere low address byte XOR 0xA5
   function automatic logic [7:0] ram(input logic [31:0] a);
      case (a)
         32'h100: return 8'h13;
         32'h101: return 8'h05;
         32'h102: return 8'hA0;
         32'h103: return 8'h00;
         default: return a[7:0] ^ 8'hA5;
      endcase
   endfunction
   always @(posedge clk) mem_din <= ram(mem_a);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Call in cycle T; returns in cycle T+7 (IDLE), ready for a back-to-back request
   task automatic fetch(input logic [31:0] a, input logic [31:0] w);
      en = 1;
      addr = a;
      for (int c = 1; c <= 6; c++) begin
         step();
         if (c <= 4) check("mem_a_seq", mem_a, a + 32'(c - 1));
         if (c == 5) check("mem_a_hold", mem_a, a + 32'd3);
         if (c <= 5) check("stat_busy", 32'(stat), 32'd1);
      end
      check("stat_handled", 32'(stat), 32'd2);
      check("data", data, w);
      check("handled_addr", haddr, a);
      if (last_h != 0) check("handled_spacing", 32'(cyc - last_h), 32'd7);
      last_h = cyc;
      en = 0;
      step();
      check("stat_idle_after", 32'(stat), 32'd0);
      check("data_hold", data, w);
   endtask

   typedef struct {logic [31:0] a; logic [31:0] w;} vec_t;
   vec_t vecs[3];

   initial begin
      vecs[0] = '{32'h100, 32'h00A00513};
      vecs[1] = '{32'h104, 32'hA2A3A0A1};
      vecs[2] = '{32'h037, 32'h9F9C9D92};
      step();
      step();
      rst = 1;
      check("rst_stat", 32'(stat), 32'd0);
      check("rst_data", data, 32'd0);
      check("rst_haddr", haddr, 32'd0);
      check("rst_mem_a", mem_a, 32'd0);
      check("mem_wr", 32'(mem_wr), 32'd0);
      // back-to-back table: each fetch is requested in the IDLE cycle right after HANDLED
      foreach (vecs[i]) fetch(vecs[i].a, vecs[i].w);
      last_h = 0;

      // redirect at cnt=2
      en = 1;
      addr = 32'h100;
      for (int c = 1; c <= 3; c++) step();
      addr = 32'h200;
      for (int k = 1; k <= 6; k++) begin
         step();
         if (k == 1) check("redir_mem_a", mem_a, 32'h200);
         if (k < 6) check("redir_busy", 32'(stat), 32'd1);
      end
      check("redir_handled", 32'(stat), 32'd2);
      check("redir_haddr", haddr, 32'h200);
      check("redir_data", data, 32'hA6A7A4A5);
      en = 0;
      step();

      // enable drop at cnt=4
      en = 1;
      addr = 32'h300;
      for (int c = 1; c <= 5; c++) step();
      en = 0;
      step();
      check("drop_stat", 32'(stat), 32'd0);
      check("drop_mem_a", mem_a, 32'd0);
      check("drop_data", data, 32'hA6A7A4A5);
      check("drop_haddr", haddr, 32'h200);
      step();
      check("drop_no_handled", 32'(stat), 32'd0);

      // reset at cnt=3
      en = 1;
      addr = 32'h104;
      for (int c = 1; c <= 4; c++) step();
      rst = 0;
      step();
      rst = 1;
      en = 0;
      check("mrst_stat", 32'(stat), 32'd0);
      check("mrst_data", data, 32'd0);
      check("mrst_haddr", haddr, 32'd0);
      check("mrst_mem_a", mem_a, 32'd0);
      step();
      check("mrst_no_handled", 32'(stat), 32'd0);
      fetch(32'h200, 32'hA6A7A4A5);
      last_h = 0;

      // address wrap
      fetch(32'hFFFFFFFE, 32'hA4A55A5B);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
